// File: rtl/seq_div_pkg.sv
// Shared types and sizing helpers for the sequential radix-2 restoring divider.
package seq_div_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_e;

   // Width of the iteration counter for a given word width.
   function automatic int unsigned cnt_width(input int unsigned word_width);
      return $clog2(word_width);
   endfunction

endpackage

// File: rtl/seq_divider_step.sv
// div_step: one restoring-division iteration (shift in next dividend bit,
// trial subtract, select). The subtract is a WORD_WIDTH+1 wide add of ~divisor with carry-in 1.
module div_step #(
   parameter int unsigned WORD_WIDTH = 8
) (
   input  logic [WORD_WIDTH-1:0] rem_i,
   input  logic                  q_msb_i,
   input  logic [WORD_WIDTH-1:0] divisor_i,
   output logic [WORD_WIDTH-1:0] rem_o,
   output logic                  q_bit_o
);

   logic [WORD_WIDTH:0] shifted;
   logic [WORD_WIDTH:0] b_inv;
   logic [WORD_WIDTH:0] trial;
   logic [WORD_WIDTH:0] sel;
   logic                c_o;
   logic                sel_msb_unused;

   always_comb begin
      shifted = {rem_i, q_msb_i};
      b_inv   = ~{1'b0, divisor_i};
      {c_o, trial} = {1'b0, shifted} + {1'b0, b_inv} + (WORD_WIDTH + 2)'(1);
      // Carry out set means no borrow: shifted >= divisor.
      q_bit_o = c_o;
      sel     = c_o ? trial : shifted;
      rem_o   = sel[WORD_WIDTH-1:0];
   end

   // The selected value is always below the divisor, so its top bit is zero.
   assign sel_msb_unused = sel[WORD_WIDTH];

endmodule

// File: rtl/seq_divider.sv
// seq_divider: iterative radix-2 restoring divider with valid/ready handshakes.
// Define SEQ_DIV_SIGNED_EN for two's complement operands (truncating division).
module seq_divider
   import seq_div_pkg::*;
#(
   parameter int unsigned WORD_WIDTH = 8
) (
   input  logic                  clk_i,
   input  logic                  rst_n_i,
   input  logic                  valid_i,
   output logic                  ready_o,
   input  logic [WORD_WIDTH-1:0] dividend_i,
   input  logic [WORD_WIDTH-1:0] divisor_i,
   output logic                  valid_o,
   input  logic                  ready_i,
   output logic [WORD_WIDTH-1:0] quotient_o,
   output logic [WORD_WIDTH-1:0] remainder_o,
   output logic                  div_zero_o
);

   localparam int unsigned CNT_W = cnt_width(WORD_WIDTH);

   state_e                state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [WORD_WIDTH-1:0] quo_sr_q, quo_sr_d;
   logic [WORD_WIDTH-1:0] rem_q, rem_d;
   logic [WORD_WIDTH-1:0] dvs_q, dvs_d;
   logic [WORD_WIDTH-1:0] quotient_q, quotient_d;
   logic [WORD_WIDTH-1:0] remainder_q, remainder_d;
   logic                  div_zero_q, div_zero_d;

   logic [WORD_WIDTH-1:0] step_rem;
   logic                  step_bit;
   logic [WORD_WIDTH-1:0] quo_next;
   logic [WORD_WIDTH-1:0] dvd_mag;
   logic [WORD_WIDTH-1:0] dvs_mag;

`ifdef SEQ_DIV_SIGNED_EN
   logic neg_quo_q, neg_quo_d;
   logic neg_rem_q, neg_rem_d;

   always_comb begin
      dvd_mag = dividend_i[WORD_WIDTH-1] ? -dividend_i : dividend_i;
      dvs_mag = divisor_i[WORD_WIDTH-1]  ? -divisor_i  : divisor_i;
   end
`else
   always_comb begin
      dvd_mag = dividend_i;
      dvs_mag = divisor_i;
   end
`endif

   div_step #(
      .WORD_WIDTH(WORD_WIDTH)
   ) u_step (
      .rem_i    (rem_q),
      .q_msb_i  (quo_sr_q[WORD_WIDTH-1]),
      .divisor_i(dvs_q),
      .rem_o    (step_rem),
      .q_bit_o  (step_bit)
   );

   assign quo_next = {quo_sr_q[WORD_WIDTH-2:0], step_bit};

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      quo_sr_d    = quo_sr_q;
      rem_d       = rem_q;
      dvs_d       = dvs_q;
      quotient_d  = quotient_q;
      remainder_d = remainder_q;
      div_zero_d  = div_zero_q;
`ifdef SEQ_DIV_SIGNED_EN
      neg_quo_d   = neg_quo_q;
      neg_rem_d   = neg_rem_q;
`endif
      ready_o     = 1'b0;
      valid_o     = 1'b0;

      case (state_q)
         IDLE: begin
            ready_o = 1'b1;
            if (valid_i) begin
               dvs_d    = dvs_mag;
               quo_sr_d = dvd_mag;
               rem_d    = '0;
               cnt_d    = CNT_W'(WORD_WIDTH - 1);
`ifdef SEQ_DIV_SIGNED_EN
               neg_quo_d = dividend_i[WORD_WIDTH-1] ^ divisor_i[WORD_WIDTH-1];
               neg_rem_d = dividend_i[WORD_WIDTH-1];
`endif
               if (divisor_i == '0) begin
                  state_d     = DONE;
                  quotient_d  = '1;
                  remainder_d = dividend_i;
                  div_zero_d  = 1'b1;
               end else begin
                  state_d = CALC;
               end
            end
         end
         CALC: begin
            quo_sr_d = quo_next;
            rem_d    = step_rem;
            if (cnt_q == '0) begin
               state_d    = DONE;
               div_zero_d = 1'b0;
`ifdef SEQ_DIV_SIGNED_EN
               // Sign fix-up rides the final iteration edge, adding no latency.
               quotient_d  = neg_quo_q ? -quo_next : quo_next;
               remainder_d = neg_rem_q ? -step_rem : step_rem;
`else
               quotient_d  = quo_next;
               remainder_d = step_rem;
`endif
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         DONE: begin
            valid_o = 1'b1;
            if (ready_i) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         quo_sr_q    <= '0;
         rem_q       <= '0;
         dvs_q       <= '0;
         quotient_q  <= '0;
         remainder_q <= '0;
         div_zero_q  <= 1'b0;
`ifdef SEQ_DIV_SIGNED_EN
         neg_quo_q   <= 1'b0;
         neg_rem_q   <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         quo_sr_q    <= quo_sr_d;
         rem_q       <= rem_d;
         dvs_q       <= dvs_d;
         quotient_q  <= quotient_d;
         remainder_q <= remainder_d;
         div_zero_q  <= div_zero_d;
`ifdef SEQ_DIV_SIGNED_EN
         neg_quo_q   <= neg_quo_d;
         neg_rem_q   <= neg_rem_d;
`endif
      end
   end

   assign quotient_o  = quotient_q;
   assign remainder_o = remainder_q;
   assign div_zero_o  = div_zero_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed-vector bench for seq_divider (WORD_WIDTH=8); vector set follows SEQ_DIV_SIGNED_EN.
module tb_seq_divider;

   localparam int unsigned W = 8;
   localparam int NVEC = 10;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         valid_i;
   logic         ready_o;
   logic [W-1:0] dividend_i;
   logic [W-1:0] divisor_i;
   logic         valid_o;
   logic         ready_i;
   logic [W-1:0] quotient_o;
   logic [W-1:0] remainder_o;
   logic         div_zero_o;

   int tests = 0;
   int fails = 0;

   typedef struct {
      string        name;
      logic [W-1:0] dvd;
      logic [W-1:0] dvs;
      logic [W-1:0] q;
      logic [W-1:0] r;
      logic         dz;
      int           lat;
   } vec_t;

   vec_t vecs[NVEC];

   always #5 clk = ~clk;

   seq_divider #(.WORD_WIDTH(W)) dut (
      .clk_i      (clk),
      .rst_n_i    (rst_n),
      .valid_i    (valid_i),
      .ready_o    (ready_o),
      .dividend_i (dividend_i),
      .divisor_i  (divisor_i),
      .valid_o    (valid_o),
      .ready_i    (ready_i),
      .quotient_o (quotient_o),
      .remainder_o(remainder_o),
      .div_zero_o (div_zero_o)
   );

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
      end
   endtask

   // Latency counts edges from the one that accepts the operands up to valid_o.
   function automatic vec_t mk(input string n, input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic [W-1:0] q, input logic [W-1:0] r, input logic dz);
      vec_t v;
      v.name = n; v.dvd = a; v.dvs = b; v.q = q; v.r = r; v.dz = dz;
      v.lat  = dz ? 1 : int'(W) + 1;
      return v;
   endfunction

   // Presents operands at a negedge, scrambles them after the accept edge, returns edges to valid_o.
   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, output int lat);
      @(negedge clk);
      check("ready before accept", 32'(ready_o), 32'd1);
      valid_i = 1'b1; dividend_i = a; divisor_i = b;
      lat = 0;
      do begin
         @(posedge clk); #1;
         lat++;
         if (lat == 1) begin
            valid_i = 1'b0;
            dividend_i = W'($urandom);
            divisor_i  = W'($urandom);
         end
      end while (!valid_o && lat < 40);
   endtask

   task automatic release_result(input string name, input logic [W-1:0] q);
      @(negedge clk);
      ready_i = 1'b1;
      @(posedge clk); #1;
      ready_i = 1'b0;
      check({name, " release"}, {30'd0, valid_o, ready_o}, 32'd1);
      check({name, " q kept"}, 32'(quotient_o), 32'(q));
   endtask

   initial begin
      int lat;
      int bad;

`ifdef SEQ_DIV_SIGNED_EN
      vecs[0] = mk("s100/7",    8'd100, 8'd7,   8'd14,  8'd2,   1'b0);
      vecs[1] = mk("s0/9",      8'd0,   8'd9,   8'd0,   8'd0,   1'b0);
      vecs[2] = mk("s3/100",    8'd3,   8'd100, 8'd0,   8'd3,   1'b0);
      vecs[3] = mk("s5/0",      8'd5,   8'd0,   8'hFF,  8'd5,   1'b1);
      vecs[4] = mk("s-7/2",     8'hF9,  8'd2,   8'hFD,  8'hFF,  1'b0);
      vecs[5] = mk("s7/-2",     8'd7,   8'hFE,  8'hFD,  8'h01,  1'b0);
      vecs[6] = mk("s-128/-1",  8'h80,  8'hFF,  8'h80,  8'h00,  1'b0);
      vecs[7] = mk("s-100/7",   8'h9C,  8'd7,   8'hF2,  8'hFE,  1'b0);
      vecs[8] = mk("s-7/0",     8'hF9,  8'd0,   8'hFF,  8'hF9,  1'b1);
      vecs[9] = mk("s127/-128", 8'h7F,  8'h80,  8'h00,  8'h7F,  1'b0);
`else
      vecs[0] = mk("u100/7",    8'd100, 8'd7,   8'd14,  8'd2,   1'b0);
      vecs[1] = mk("u255/1",    8'd255, 8'd1,   8'd255, 8'd0,   1'b0);
      vecs[2] = mk("u3/200",    8'd3,   8'd200, 8'd0,   8'd3,   1'b0);
      vecs[3] = mk("u0/9",      8'd0,   8'd9,   8'd0,   8'd0,   1'b0);
      vecs[4] = mk("u255/255",  8'd255, 8'd255, 8'd1,   8'd0,   1'b0);
      vecs[5] = mk("u5/0",      8'd5,   8'd0,   8'hFF,  8'd5,   1'b1);
      vecs[6] = mk("u9/2",      8'd9,   8'd2,   8'd4,   8'd1,   1'b0);
      vecs[7] = mk("u200/13",   8'd200, 8'd13,  8'd15,  8'd5,   1'b0);
      vecs[8] = mk("u128/128",  8'd128, 8'd128, 8'd1,   8'd0,   1'b0);
      vecs[9] = mk("u254/0",    8'd254, 8'd0,   8'hFF,  8'd254, 1'b1);
`endif

      rst_n = 1'b0; valid_i = 1'b0; ready_i = 1'b0;
      dividend_i = '0; divisor_i = '0;
      #12;
      check("reset ready/valid", {30'd0, ready_o, valid_o}, 32'd2);
      check("reset outputs", {15'd0, div_zero_o, quotient_o, remainder_o}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < NVEC; i++) begin
         run_op(vecs[i].dvd, vecs[i].dvs, lat);
         check({vecs[i].name, " latency"}, 32'(lat), 32'(vecs[i].lat));
         check({vecs[i].name, " quotient"}, 32'(quotient_o), 32'(vecs[i].q));
         check({vecs[i].name, " remainder"}, 32'(remainder_o), 32'(vecs[i].r));
         check({vecs[i].name, " div_zero"}, 32'(div_zero_o), 32'(vecs[i].dz));
         check({vecs[i].name, " ready in DONE"}, 32'(ready_o), 32'd0);
         release_result(vecs[i].name, vecs[i].q);
      end

      // valid_i held high with different operands throughout CALC must be ignored.
      @(negedge clk);
      valid_i = 1'b1; dividend_i = 8'd100; divisor_i = 8'd7;
      @(posedge clk); #1;
      dividend_i = 8'd9; divisor_i = 8'd2;
      bad = 0; lat = 1;
      while (!valid_o && lat < 40) begin
         if (ready_o) bad++;
         @(posedge clk); #1;
         lat++;
      end
      valid_i = 1'b0;
      check("calc ignores valid_i", 32'(bad), 32'd0);
      check("bp latency", 32'(lat), 32'(W + 1));
      for (int c = 0; c < 10; c++) begin
         @(posedge clk); #1;
         check("bp hold", {14'd0, valid_o, ready_o, quotient_o, remainder_o},
               {14'd0, 1'b1, 1'b0, 8'd14, 8'd2});
      end
      release_result("bp", 8'd14);
      check("bp remainder kept", 32'(remainder_o), 32'd2);

      // Abort during the fourth iteration of 100/7.
      @(negedge clk);
      valid_i = 1'b1; dividend_i = 8'd100; divisor_i = 8'd7;
      @(posedge clk); #1;
      valid_i = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      check("mid-calc busy", 32'(ready_o), 32'd0);
      rst_n = 1'b0;
      #1;
      check("abort ready/valid", {30'd0, ready_o, valid_o}, 32'd2);
      check("abort outputs", {15'd0, div_zero_o, quotient_o, remainder_o}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      run_op(8'd9, 8'd2, lat);
      check("post-abort latency", 32'(lat), 32'(W + 1));
      check("post-abort result", {16'd0, quotient_o, remainder_o}, {16'd0, 8'd4, 8'd1});
      release_result("post-abort", 8'd4);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, fails);
      $fatal(1, "timeout");
   end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
Iterative radix-2 restoring divider. It is the inverse operation to the team's adder/look-ahead arithmetic blocks and produces one quotient bit per clock using a single trial subtraction. It sits beside the ALU as a multi-cycle functional unit. Operands enter and results leave through valid/ready handshakes.

Parameters:
WORD_WIDTH, 8, width of dividend, divisor, quotient and remainder (minimum 2)

Ports:
clk_i  input  1  clock, rising edge
rst_n_i  input  1  reset, asynchronous assert, active-low
valid_i  input  1  operands present
ready_o  output  1  unit can accept operands
dividend_i  input  WORD_WIDTH  dividend
divisor_i  input  WORD_WIDTH  divisor
valid_o  output  1  result present
ready_i  input  1  consumer takes result
quotient_o  output  WORD_WIDTH  quotient
remainder_o  output  WORD_WIDTH  remainder
div_zero_o  output  1  divisor was zero; qualified by valid_o

Behaviour:
- Clocking and reset: one clock, clk_i. Reset rst_n_i is asynchronous and active-low.
- Values in reset:
  - FSM goes to IDLE.
  - ready_o=1, valid_o=0.
  - quotient_o, remainder_o and div_zero_o are all 0.
  - Iteration counter is 0.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - ready_o=1.
  - On a rising edge with valid_i&ready_o, latch the divisor. Load the quotient shift register with the dividend and clear the partial remainder R. Set the counter to WORD_WIDTH-1.
  - Next state: CALC if the divisor is non-zero, else DONE with div_zero set.
- CALC:
  - ready_o=0.
  - Each edge: shifted = {R[W-2:0], Q[W-1]} with one extra high bit kept (R is W+1 bits internally). trial = shifted - divisor.
  - If trial is non-negative: R=trial and shift 1 into Q. Otherwise: R=shifted and shift 0 into Q.
  - At counter==0, go to DONE; otherwise decrement the counter.
- Latency: accepting at edge T gives valid_o=1 after edge T+WORD_WIDTH. Divide-by-zero gives valid_o after edge T+1.
- DONE:
  - valid_o=1. quotient_o, remainder_o and div_zero_o stay stable while ready_i=0.
  - On an edge with ready_i=1, go to IDLE and drop valid_o. The outputs keep their last values.
  - No new operand is accepted in that same edge: ready_o=0 in DONE, so throughput is one op per WORD_WIDTH+2 cycles.
- Divide-by-zero result: quotient_o = all ones, remainder_o = dividend, div_zero_o=1.
- Ignored inputs: valid_i while ready_o=0 is ignored. Operand changes during CALC are ignored.
- Reset mid-operation: asserting rst_n_i in CALC or DONE aborts immediately to the reset values. Any partial result is discarded.

Optional Feature:
Macro: SEQ_DIV_SIGNED_EN

With SEQ_DIV_SIGNED_EN defined:
- Operands are two's complement.
- On accept, absolute values are taken and the result signs are latched.
- The quotient is negated if the operand signs differ, with truncation toward zero.
- The remainder takes the sign of the dividend.
- Negation happens on the CALC->DONE edge, so there is no extra latency.
- Overflow case (most negative value) / -1 gives quotient = most negative value, remainder=0, div_zero_o=0.
- Divide-by-zero behaves as in the unsigned case (quotient all ones, remainder = raw dividend).

Without the macro: unsigned only, and no sign logic is synthesized.

Decomposition:
- Shared package seq_div_pkg holds:
  - The FSM state enum typedef (IDLE, CALC, DONE).
  - The counter width constant, computed as $clog2(WORD_WIDTH).
- One natural sub-module: div_step, the combinational trial-subtract/select stage.
  - It wraps the existing CLAA, sized WORD_WIDTH+1, with b_i = ~divisor and c_i=1.
  - The carry out c_o=1 means trial is non-negative.

Test Plan:
- Unsigned, WORD_WIDTH=8: 100/7 -> quotient_o=14, remainder_o=2, div_zero_o=0, valid_o rising exactly 8 edges after accept.
- Boundaries: 255/1 -> 255 r 0; 3/200 -> 0 r 3; 0/9 -> 0 r 0; 255/255 -> 1 r 0.
- Divide-by-zero: 5/0 -> quotient_o=0xFF, remainder_o=5, div_zero_o=1, valid_o after 1 edge.
- Backpressure: with ready_i=0 for 10 cycles in DONE, outputs stay stable and ready_o stays 0. Then ready_i=1 -> IDLE next edge, and valid_i asserted during CALC is not accepted.
- Reset mid-CALC: pull rst_n_i low at iteration 4 of 100/7 -> outputs immediately 0, ready_o=1. A subsequent 9/2 gives 4 r 1.
- SEQ_DIV_SIGNED_EN:
  - -7/2 -> 0xFD r 0xFF.
  - 7/-2 -> 0xFD r 1.
  - -128/-1 -> 0x80 r 0.
